// File: rtl/regfile_dump_pkg.sv
// Shared constants for the register-file debug dump engine: FSM encoding,
// register count and the address reported on the checksum word.
package regfile_dump_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_SEND = 3'd2;
  localparam state_t ST_SUM  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  // m_addr value carried by the trailing checksum word
  localparam int SUM_ADDR = 0;

endpackage

// File: rtl/register_file.sv
// Register file with one write port and two combinational read ports;
// register 0 is hard-wired to zero.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg_1,
  output logic [DATA_W-1:0] read_data_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_2
);

  localparam int NUM = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM];

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] val_q;
        always_ff @(posedge clk) begin
          if (!reset) begin
            val_q <= '0;
          end else if (reg_write && (write_reg == ADDR_W'(gi))) begin
            val_q <= write_data;
          end
        end
        assign regs[gi] = val_q;
      end
    end
  endgenerate

  assign read_data_1 = regs[read_reg_1];
  assign read_data_2 = regs[read_reg_2];

endmodule

// File: rtl/regfile_dump.sv
// Walks every register through an async read port, streams each value over
// valid/ready and finishes with an XOR checksum word flagged by m_last.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((2 ** ADDR_W) - 1);

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] idx_q,     idx_d;
  logic [DATA_W-1:0] sum_q,     sum_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q,  m_last_d;
  logic              done_q,    done_d;

  logic handshake;

  assign handshake = m_valid_q & m_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    m_data_d  = m_data_q;
    m_addr_d  = m_addr_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        if (start) begin
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // the register is sampled here, so later writes to it are not seen
          m_data_d  = rd_data;
          m_addr_d  = idx_q;
          sum_d     = sum_q ^ rd_data;
          m_valid_d = 1'b1;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (abort) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (handshake) begin
          if (idx_q == LAST_IDX) begin
            m_data_d = sum_q;
            m_addr_d = ADDR_W'(SUM_ADDR);
            m_last_d = 1'b1;
            state_d  = ST_SUM;
          end else begin
            idx_d     = idx_q + 1'b1;
            m_valid_d = 1'b0;
            state_d   = ST_LOAD;
          end
        end
      end

      ST_SUM: begin
        if (abort) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = ST_IDLE;
        end else if (handshake) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      sum_q     <= '0;
      m_data_q  <= '0;
      m_addr_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      m_data_q  <= m_data_d;
      m_addr_q  <= m_addr_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr = (state_q == ST_IDLE) ? '0 : idx_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_addr  = m_addr_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump driving a real register_file: full dumps,
// back-pressure, mid-dump writes, abort, ignored start and mid-dump reset.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, m_ready;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, rd_data_1;
  logic        m_valid, m_last, busy, done;
  logic [31:0] m_data;
  logic [4:0]  m_addr;

  always #5 clk = ~clk;

  register_file #(.DATA_W(32), .ADDR_W(5)) u_rf (
    .clk(clk), .reset(rst_n), .reg_write(wr_en), .write_reg(wr_reg),
    .write_data(wr_data), .read_reg_1(5'd0), .read_data_1(rd_data_1),
    .read_reg_2(rd_addr), .read_data_2(rd_data)
  );

  regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .m_last(m_last),
    .busy(busy), .done(done)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: accepted words, done pulses and hold-stability while stalled
  vec_t        words[$];
  vec_t        rec;
  int          done_cnt = 0;
  int          done_edge = 0;
  int          stab_err = 0;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [37:0] prev_word = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready && !abort) begin
        rec.addr = m_addr;
        rec.data = m_data;
        rec.last = m_last;
        rec.cyc  = edge_cnt;
        words.push_back(rec);
      end
      if (done) begin
        done_cnt++;
        done_edge = edge_cnt;
      end
      if (prev_valid && !prev_hs && m_valid && ({m_addr, m_data, m_last} != prev_word))
        stab_err++;
      prev_valid = m_valid;
      prev_hs    = m_valid && m_ready && !abort;
      prev_word  = {m_addr, m_data, m_last};
    end else begin
      prev_valid = 1'b0;
    end
  end

  int passed = 0;
  int total  = 0;
  int start_edge = 0;
  int wbase = 0;
  int dbase = 0;
  int sbase = 0;
  logic [31:0] preload_val [32];
  vec_t        exp1 [33];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] pack(input vec_t v);
    return {26'b0, v.addr, v.data, v.last};
  endfunction

  function automatic int cyc_of(input int e);
    return e - start_edge + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_reg = 5'(i); wr_data = preload_val[i];
      tick();
    end
    wr_en = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    wbase = words.size();
    dbase = done_cnt;
    sbase = stab_err;
    start = 1'b1;
    tick();
    start_edge = edge_cnt;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 300 && done_cnt == dbase; n++) tick();
    check(name, 64'(done_cnt - dbase), 64'd1);
  endtask

  task automatic check_summary(input string tag, input logic [31:0] sum, input int done_cyc);
    vec_t v;
    check({tag, "_count"}, 64'(words.size() - wbase), 64'd33);
    if (words.size() - wbase >= 33) begin
      v = words[wbase + 32];
      check({tag, "_checksum"}, 64'({v.addr, v.data, v.last}), 64'({5'd0, sum, 1'b1}));
    end
    check({tag, "_done_cycle"}, 64'(cyc_of(done_edge)), 64'(done_cyc));
    check({tag, "_stable"}, 64'(stab_err - sbase), 64'd0);
  endtask

  initial begin
    logic stalled, wrote, aborted;
    vec_t v;

    for (int i = 0; i < 32; i++) preload_val[i] = 32'h0;
    preload_val[1]  = 32'h1111_1111;
    preload_val[2]  = 32'h2222_2222;
    preload_val[31] = 32'hFFFF_FFFF;
    for (int k = 0; k < 32; k++) exp1[k] = '{addr: 5'(k), data: preload_val[k], last: 1'b0, cyc: 2 + 2 * k};
    exp1[32] = '{addr: 5'd0, data: 32'hCCCC_CCCC, last: 1'b1, cyc: 65};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    wr_en = 1'b0; wr_reg = '0; wr_data = '0;
    repeat (3) tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last",  64'(m_last),  64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    check("rst_m_addr",  64'(m_addr),  64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: full dump with m_ready held high
    preload();
    pulse_start();
    check("s1_busy_c1",  64'(busy),    64'd1);
    check("s1_valid_c1", 64'(m_valid), 64'd0);
    tick();
    check("s1_valid_c2", 64'(m_valid), 64'd1);
    wait_done("s1_done_seen");
    check("s1_busy_c67", 64'(busy), 64'd0);
    check_summary("s1", 32'hCCCC_CCCC, 66);
    for (int k = 0; k < 33 && wbase + k < words.size(); k++) begin
      v = words[wbase + k];
      check($sformatf("s1_word%0d", k), pack(v), pack(exp1[k]));
      check($sformatf("s1_word%0d_cycle", k), 64'(cyc_of(v.cyc)), 64'(exp1[k].cyc));
    end

    // Scenario 2: 5-cycle stall during r2's SEND
    preload();
    pulse_start();
    stalled = 1'b0;
    for (int n = 0; n < 300 && done_cnt == dbase; n++) begin
      tick();
      if (!stalled && m_valid && m_addr == 5'd2) begin
        m_ready = 1'b0;
        repeat (5) tick();
        m_ready = 1'b1;
        stalled = 1'b1;
      end
    end
    check("s2_stall_applied", 64'(stalled), 64'd1);
    check_summary("s2", 32'hCCCC_CCCC, 71);
    if (words.size() - wbase > 2) begin
      v = words[wbase + 2];
      check("s2_r2_word", 64'({v.addr, v.data}), 64'({5'd2, 32'h2222_2222}));
      check("s2_r2_cycle", 64'(cyc_of(v.cyc)), 64'd11);
    end

    // Scenario 3: writes to r10 then r3 while r5 is held in SEND
    preload();
    pulse_start();
    wrote = 1'b0;
    for (int n = 0; n < 300 && done_cnt == dbase; n++) begin
      tick();
      if (!wrote && m_valid && m_addr == 5'd5) begin
        m_ready = 1'b0;
        wr_en = 1'b1; wr_reg = 5'd10; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_reg = 5'd3; wr_data = 32'h1234_5678;
        tick();
        wr_en = 1'b0;
        m_ready = 1'b1;
        wrote = 1'b1;
      end
    end
    check("s3_writes_applied", 64'(wrote), 64'd1);
    check_summary("s3", 32'h1261_7223, 68);
    if (words.size() - wbase > 10) begin
      v = words[wbase + 10];
      check("s3_r10_word", 64'({v.addr, v.data}), 64'({5'd10, 32'hDEAD_BEEF}));
      v = words[wbase + 3];
      check("s3_r3_word", 64'({v.addr, v.data}), 64'({5'd3, 32'h0}));
    end

    // Scenario 4: abort during r7's SEND with m_ready high, then restart
    preload();
    pulse_start();
    aborted = 1'b0;
    for (int n = 0; n < 100 && !aborted; n++) begin
      tick();
      if (m_valid && m_addr == 5'd7) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        aborted = 1'b1;
        check("s4_valid_after_abort", 64'(m_valid), 64'd0);
        check("s4_busy_after_abort",  64'(busy),    64'd0);
      end
    end
    check("s4_abort_applied", 64'(aborted), 64'd1);
    repeat (5) tick();
    check("s4_no_done", 64'(done_cnt - dbase), 64'd0);
    check("s4_words_before_abort", 64'(words.size() - wbase), 64'd7);
    check("s4_rd_addr_idle", 64'(rd_addr), 64'd0);
    pulse_start();
    wait_done("s4_restart_done_seen");
    check_summary("s4", 32'hCCCC_CCCC, 66);
    if (words.size() > wbase) begin
      v = words[wbase];
      check("s4_first_word", pack(v), pack(exp1[0]));
    end

    // Scenario 5: start repeated in cycle 20 is ignored
    pulse_start();
    for (int n = 0; n < 100 && cyc_of(edge_cnt) < 20; n++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("s5_done_seen");
    repeat (4) tick();
    check("s5_busy_after", 64'(busy), 64'd0);
    check_summary("s5", 32'hCCCC_CCCC, 66);

    // Scenario 6: reset during LOAD of r12
    pulse_start();
    for (int n = 0; n < 100 && rd_addr != 5'd12; n++) tick();
    check("s6_load_r12_cycle", 64'(cyc_of(edge_cnt)), 64'd25);
    rst_n = 1'b0;
    tick();
    check("s6_m_valid", 64'(m_valid), 64'd0);
    check("s6_m_last",  64'(m_last),  64'd0);
    check("s6_busy",    64'(busy),    64'd0);
    check("s6_done",    64'(done),    64'd0);
    check("s6_m_data",  64'(m_data),  64'd0);
    check("s6_m_addr",  64'(m_addr),  64'd0);
    check("s6_rd_addr", 64'(rd_addr), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("s6_idle_valid", 64'(m_valid), 64'd0);
    check("s6_idle_busy",  64'(busy),    64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
